if_id_pipe_stage: RTL
=====================

Name: if_id_pipe_stage

Overview:
- Parametrised successor to the fixed 32-bit IF/ID latch.
- Carries an instruction word plus PC from fetch to decode using a valid/ready handshake.
- An optional 2-entry skid buffer gives a fully registered backpressure path, so `in_ready` has no combinational dependency on `out_ready`.
- Adds flush (branch/jump squash) and NOP bubble insertion; used between fetch and decode, and reusable at any pipeline boundary.

Parameters:
- INSTR_WIDTH, 32, width of the instruction field.
- PC_WIDTH, 32, width of the PC field.
- NOP_INSTR, 32'h00000013, instruction presented on `out_instr` whenever the stage holds no valid entry (RV32 addi x0,x0,0); width INSTR_WIDTH.
- SKID_EN, 1:
  - 1 = two entries (main + skid), registered `in_ready`.
  - 0 = single entry, combinational `in_ready`.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- flush  input  1  squash all held entries
- in_valid  input  1  upstream entry valid
- in_ready  output  1  stage can accept this cycle
- in_instr  input  INSTR_WIDTH  upstream instruction
- in_pc  input  PC_WIDTH  upstream PC
- out_valid  output  1  main entry valid
- out_ready  input  1  downstream accepts
- out_instr  output  INSTR_WIDTH  main instruction, or NOP_INSTR when !out_valid
- out_pc  output  PC_WIDTH  main PC (value undefined for consumer when !out_valid, but deterministic)
- occupancy  output  2  entries held (0..2; max 1 when SKID_EN=0)

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset:
  - main_valid=0, skid_valid=0, all data/PC registers cleared to 0.
  - Next cycle: out_valid=0, out_instr=NOP_INSTR, out_pc=0, occupancy=0, in_ready=1.
  - Reset overrides flush and any handshake in the same cycle.
- Handshakes:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - Data transfers only on a fire.
  - in_instr and in_pc are sampled only on in_fire.
- in_ready:
  - SKID_EN=1: in_ready = !skid_valid, purely from a register.
  - SKID_EN=0: in_ready = !main_valid | out_ready.
- Latency: an entry accepted at edge N appears on out_* after edge N (1 cycle) when the stage was empty.
- Main register update, in priority order:
  1. If flush: main_valid<=0.
  2. Else if (!main_valid | out_fire) and skid_valid: main <= skid.
  3. Else if (!main_valid | out_fire) and in_fire: main <= input.
  4. Else if out_fire: main_valid<=0.
  5. Else: hold.
- Skid register (SKID_EN=1 only):
  - If flush: skid_valid<=0.
  - Else if in_fire, main_valid, and !out_fire: skid <= input, skid_valid<=1.
  - Else if skid moved to main: skid_valid<=0.
- Ordering: entries leave strictly in acceptance order. Skid-to-main and input-to-skid may occur in the same cycle only if skid was empty. This cannot happen because in_ready=0 while skid_valid=1.
- Flush:
  - All valids clear next cycle.
  - An in_fire in the flush cycle is discarded; upstream sees it as accepted.
  - An out_fire in the flush cycle still completes downstream; flush applies to what remains.
- Full (occupancy=2): in_ready=0. Out data holds stable while out_valid & !out_ready (AXI-style stability).
- Empty: out_valid=0 and out_instr=NOP_INSTR, a combinational mux on main_valid.
- Simultaneous in_fire and out_fire with occupancy=1: pass-through; occupancy stays 1.
- occupancy = main_valid + skid_valid, registered.
- Data registers are not cleared on flush; only the valid bits are cleared.
- Invariant: skid_valid implies main_valid. The bench asserts this.

Decomposition:
- Shared package holds:
  - default widths XLEN=32;
  - the NOP_INSTR constant RV_NOP=32'h00000013;
  - an entry struct {instr, pc}.
- One natural sub-module: pipe_entry_reg, a single valid+payload register with load/clear/hold.
  - Instantiated twice: main, and skid under generate on SKID_EN.
- Handshake control stays in the top module.

Test Plan:
- Reset release:
  - Stimulus: assert reset 2 cycles with in_valid=1.
  - Required: out_valid=0, out_instr=32'h00000013, out_pc=0, occupancy=0, in_ready=1.
- Streaming:
  - Stimulus: out_ready=1; send instr 0x00500093/pc 0x0, then 0x00a00113/pc 0x4 on consecutive cycles.
  - Required: each appears one cycle later, occupancy=1 throughout, no bubbles.
- Backpressure fill:
  - Stimulus: out_ready=0; send pc 0x8, 0xC, 0x10.
  - Required: first two accepted, occupancy=2, in_ready=0 on the 3rd cycle, out_pc stays 0x8.
  - Then raise out_ready: outputs are 0x8, 0xC, 0x10 in order.
- Flush while full:
  - Stimulus: occupancy=2, assert flush one cycle with in_valid=1 pc 0x20.
  - Required: next cycle out_valid=0, out_instr=NOP, occupancy=0; pc 0x20 never appears.
- Flush with out_fire:
  - Stimulus: occupancy=1 pc 0x14, out_ready=1, flush=1.
  - Required: 0x14 consumed that cycle, occupancy=0 after.
- SKID_EN=0 build:
  - Stimulus: out_ready=0 with main full.
  - Required: in_ready=0 combinationally; raising out_ready the same cycle makes in_ready=1 and the pass-through completes.
  - Required: occupancy never exceeds 1.

Source files
------------

// File: rtl/if_id_pipe_stage_pkg.sv
// Shared widths, the RV32 NOP encoding and the fetch/decode entry layout
// for the IF/ID pipeline stage.
package if_id_pipe_stage_pkg;

    // Default datapath width for instruction and PC fields.
    localparam int unsigned XLEN = 32;

    // RV32 canonical NOP: addi x0, x0, 0.
    localparam logic [XLEN-1:0] RV_NOP = 32'h00000013;

    // One fetched entry as it travels from fetch to decode.
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } entry_t;

    // Number of occupied slots given the main and skid valid bits.
    function automatic logic [1:0] count_valid(input logic main_v, input logic skid_v);
        return {1'b0, main_v} + {1'b0, skid_v};
    endfunction

endpackage

// File: rtl/if_id_pipe_stage_entry.sv
// Single valid + payload register. Clear drops only the valid bit so the
// payload keeps its last value; reset clears both.
module pipe_entry_reg #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] data_in,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    // Reset wins, then clear (squash), then load, otherwise hold.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= data_in;
        end
    end

endmodule

// File: rtl/if_id_pipe_stage.sv
// IF/ID pipeline stage: carries {instr, pc} from fetch to decode over a
// valid/ready handshake, with optional skid entry, flush and NOP bubbles.
module if_id_pipe_stage
    import if_id_pipe_stage_pkg::*;
#(
    parameter int unsigned             INSTR_WIDTH = XLEN,
    parameter int unsigned             PC_WIDTH    = XLEN,
    parameter logic [INSTR_WIDTH-1:0]  NOP_INSTR   = INSTR_WIDTH'(RV_NOP),
    parameter bit                      SKID_EN     = 1'b1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INSTR_WIDTH-1:0] in_instr,
    input  logic [PC_WIDTH-1:0]    in_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INSTR_WIDTH-1:0] out_instr,
    output logic [PC_WIDTH-1:0]    out_pc,
    output logic [1:0]             occupancy
);

    localparam int unsigned PW = INSTR_WIDTH + PC_WIDTH;

    logic          main_valid;
    logic [PW-1:0] main_data;
    logic          skid_valid;
    logic [PW-1:0] skid_data;
    logic [PW-1:0] in_data;

    logic          in_fire;
    logic          out_fire;
    logic          main_take;
    logic          main_load_skid;
    logic          main_load_in;
    logic          main_load;
    logic          main_clear;
    logic [PW-1:0] main_din;

    assign in_data = {in_instr, in_pc};

    // Handshakes and the prioritised main-entry update decision.
    always_comb begin
        in_fire        = in_valid & in_ready;
        out_fire       = main_valid & out_ready;
        main_take      = ~main_valid | out_fire;
        // A held skid entry is older than anything arriving now, so it goes first.
        main_load_skid = ~flush & main_take & skid_valid;
        main_load_in   = ~flush & main_take & ~skid_valid & in_fire;
        main_load      = main_load_skid | main_load_in;
        main_clear     = flush | (out_fire & ~main_load);
        main_din       = skid_valid ? skid_data : in_data;
    end

    pipe_entry_reg #(
        .WIDTH (PW)
    ) u_main (
        .clock   (clock),
        .reset   (reset),
        .load    (main_load),
        .clear   (main_clear),
        .data_in (main_din),
        .valid   (main_valid),
        .data    (main_data)
    );

    generate
        if (SKID_EN) begin : g_skid
            logic skid_load;
            logic skid_clear;

            // Input parks in skid only when main is occupied and not draining.
            assign skid_load  = ~flush & in_fire & main_valid & ~out_fire;
            assign skid_clear = flush | main_load_skid;

            pipe_entry_reg #(
                .WIDTH (PW)
            ) u_skid (
                .clock   (clock),
                .reset   (reset),
                .load    (skid_load),
                .clear   (skid_clear),
                .data_in (in_data),
                .valid   (skid_valid),
                .data    (skid_data)
            );

            // Ready comes straight from a flop: no path from out_ready.
            assign in_ready = ~skid_valid;
        end else begin : g_no_skid
            assign skid_valid = 1'b0;
            assign skid_data  = '0;
            assign in_ready   = ~main_valid | out_ready;
        end
    endgenerate

    // Output view of the main entry; an empty stage presents a NOP bubble.
    always_comb begin
        out_valid = main_valid;
        out_instr = main_valid ? main_data[PW-1:PC_WIDTH] : NOP_INSTR;
        out_pc    = main_data[PC_WIDTH-1:0];
        occupancy = count_valid(main_valid, skid_valid);
    end

endmodule
